// File: rtl/sort_host_ctrl.sv
// Host-side controller for the sorter: streams a job of DEPTH words into the
// sorter RAM, kicks off a sort, waits for completion and streams the sorted
// words back out with a last marker.
module sort_host_ctrl #(
    parameter int unsigned N       = 8,
    parameter int unsigned L       = 4,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         err_timeout,
    output logic         WrInit,
    output logic         Rd,
    output logic [L-1:0] RAddr,
    output logic [N-1:0] DataIn,
    output logic         start,
    input  logic [N-1:0] DataOut,
    input  logic         done
);

    localparam int unsigned CW = L + 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_RD_ISSUE,
        S_RD_CAP,
        S_OUT_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q;
    logic [CW-1:0] rcnt_q;
    logic [TW-1:0] tcnt_q;
    logic          hs_in;
    logic          timeout_c;

    // in_ready is only ever high in IDLE/LOAD, so this is the load handshake
    assign hs_in = in_valid & in_ready;

    // Next-state decode plus the sorter-side strobes (RAM write follows the handshake directly)
    always_comb begin
        state_d   = state_q;
        timeout_c = 1'b0;
        WrInit    = 1'b0;
        Rd        = 1'b0;
        start     = 1'b0;
        RAddr     = '0;
        DataIn    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (hs_in) begin
                    WrInit  = 1'b1;
                    RAddr   = L'(wcnt_q);
                    DataIn  = in_data;
                    state_d = (DEPTH == 1) ? S_START : S_LOAD;
                end
            end
            S_LOAD: begin
                if (hs_in) begin
                    WrInit = 1'b1;
                    RAddr  = L'(wcnt_q);
                    DataIn = in_data;
                    if (wcnt_q == LAST_IDX) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                start   = 1'b1;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!done) begin
                    state_d = S_WAIT_HI;
                end else if (tcnt_q + TW'(1) == T_LAST) begin
                    timeout_c = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_WAIT_HI: begin
                if (done) begin
                    state_d = S_RD_ISSUE;
                end else if (tcnt_q + TW'(1) == T_LAST) begin
                    timeout_c = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RD_ISSUE: begin
                Rd      = 1'b1;
                RAddr   = L'(rcnt_q);
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                state_d = S_OUT_HOLD;
            end
            S_OUT_HOLD: begin
                if (out_ready) begin
                    state_d = out_last ? S_IDLE : S_RD_ISSUE;
                end
            end
        endcase
    end

    // State, counters and registered stream outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            tcnt_q      <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d == S_IDLE) || (state_d == S_LOAD);
            busy     <= (state_d != S_IDLE);
            if (timeout_c) begin
                err_timeout <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (hs_in) begin
                        wcnt_q <= CW'(1);
                    end
                end
                S_LOAD: begin
                    if (hs_in) begin
                        wcnt_q <= wcnt_q + CW'(1);
                    end
                end
                S_START: begin
                    wcnt_q <= '0;
                    tcnt_q <= '0;
                end
                S_WAIT_LO: begin
                    tcnt_q <= tcnt_q + TW'(1);
                end
                S_WAIT_HI: begin
                    tcnt_q <= tcnt_q + TW'(1);
                    if (done) begin
                        rcnt_q <= '0;
                    end
                end
                S_RD_ISSUE: begin
                end
                S_RD_CAP: begin
                    out_data  <= DataOut;
                    out_last  <= (rcnt_q == LAST_IDX);
                    out_valid <= 1'b1;
                end
                S_OUT_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (!out_last) begin
                            rcnt_q <= rcnt_q + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_host_ctrl.sv
// Bench for sort_host_ctrl: a behavioural sorter sits on the RAM port and a
// sorted copy of each job's input is the expected output stream.
module tb_sort_host_ctrl;

    localparam int N       = 8;
    localparam int L       = 4;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int LAT     = 5;
    localparam int AW      = $clog2(DEPTH);

    typedef logic [N-1:0] arr_t [DEPTH];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [N-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic [N-1:0] DataOut = '0;
    logic         done = 1'b0;
    logic         in_ready, out_valid, out_last, busy, err_timeout;
    logic         WrInit, Rd, start;
    logic [N-1:0] out_data, DataIn;
    logic [L-1:0] RAddr;

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;   // 0 normal sorter, 1 done stuck low, 2 stale-done pattern
    int sc       = 0;   // cycles since start, 0 when idle
    arr_t ram;

    always #5 clk = ~clk;

    sort_host_ctrl #(.N(N), .L(L), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_timeout(err_timeout),
        .WrInit(WrInit), .Rd(Rd), .RAddr(RAddr), .DataIn(DataIn),
        .start(start), .DataOut(DataOut), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic arr_t sort_arr(input arr_t a);
        arr_t r;
        logic [N-1:0] t;
        r = a;
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH - 1 - i; j++)
                if (r[j] > r[j+1]) begin t = r[j]; r[j] = r[j+1]; r[j+1] = t; end
        return r;
    endfunction

    // Behavioural sorter: RAM with registered read, sorts in place some cycles after start
    always @(posedge clk) begin
        if (WrInit) ram[RAddr[AW-1:0]] <= DataIn;
        if (Rd) DataOut <= ram[RAddr[AW-1:0]];
        if (start) begin
            sc   <= 1;
            done <= (mode == 2);
        end else if (sc != 0) begin
            sc <= sc + 1;
            if (mode == 0 && sc == LAT) begin
                ram  <= sort_arr(ram);
                done <= 1'b1;
            end else if (mode == 2) begin
                done <= (sc + 1 <= 3) || (sc + 1 >= 14);
                if (sc + 1 == 14) ram <= sort_arr(ram);
            end else if (mode == 1) begin
                done <= 1'b0;
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err_timeout", err_timeout, 1'b0);
        chk("rst_wrinit", WrInit, 1'b0);
        chk("rst_rd", Rd, 1'b0);
        chk("rst_raddr", RAddr, 4'h0);
        chk("rst_datain", DataIn, 8'h00);
        chk("rst_start", start, 1'b0);
    endtask

    // One job: load d with the given gap style, then watch start/wait/readback.
    task automatic run_job(input arr_t d, input int gap, input int bp_word, input int bp_len,
                           input int rnd_bp, input int stop_at, input int exp_rd_lat,
                           input bit expect_to);
        arr_t exp;
        int idx, cyc, wr_cnt, start_cnt, start_cyc, rd_cnt, rd_cyc, first_rd, out_idx, held;
        bit hs, p_ov, p_hs, p_err, err_seen, ov_seen, stopped, to_now;
        logic [N-1:0] p_data;
        exp = sort_arr(d);
        idx = 0; cyc = 0; wr_cnt = 0;
        while (idx < DEPTH && cyc < 100) begin
            @(posedge clk); #1;
            case (gap)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = d[idx];
            @(negedge clk);
            hs = in_valid && in_ready;
            chk("wrinit_vs_handshake", WrInit, hs);
            chk("no_start_in_load", start, 1'b0);
            if (hs) begin
                chk("wr_addr", RAddr, L'(idx));
                chk("wr_data", DataIn, d[idx]);
                wr_cnt++;
                idx++;
            end
            cyc++;
        end
        chk("wr_count", wr_cnt, DEPTH);

        cyc = 0; start_cnt = 0; start_cyc = -1000; rd_cnt = 0; rd_cyc = -1000; first_rd = -1;
        out_idx = 0; held = 0; p_ov = 0; p_hs = 0; p_data = '0; p_err = err_timeout;
        err_seen = 0; ov_seen = 0; stopped = 0;
        while (out_idx < DEPTH && !err_seen && !stopped && cyc < 400) begin
            @(posedge clk); #1;
            in_valid = expect_to ? 1'b0 : 1'($urandom_range(0, 1));
            in_data  = N'($urandom);
            if (out_idx == stop_at || (out_idx == bp_word && held < bp_len)) out_ready = 1'b0;
            else out_ready = (rnd_bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            to_now = err_timeout && !p_err;
            p_err  = err_timeout;
            chk("no_wrinit_after_load", WrInit, 1'b0);
            chk("strobe_exclusive", (int'(start) + int'(Rd) + int'(WrInit)) <= 1, 1'b1);
            if (to_now) begin
                err_seen = 1;
                chk("timeout_latency", cyc - start_cyc, TIMEOUT);
                chk("busy_after_timeout", busy, 1'b0);
                chk("in_ready_after_timeout", in_ready, 1'b1);
            end else begin
                chk("in_ready_low", in_ready, 1'b0);
                chk("busy_in_job", busy, 1'b1);
                if (start) begin start_cnt++; start_cyc = cyc; end
                if (Rd) begin
                    chk("rd_addr", RAddr, L'(out_idx));
                    chk("rd_while_valid", out_valid, 1'b0);
                    if (first_rd < 0) first_rd = cyc;
                    rd_cnt++;
                    rd_cyc = cyc;
                end else begin
                    chk("raddr_idle", RAddr, 4'h0);
                end
                if (out_valid && !p_ov) chk("valid_after_rd", cyc - rd_cyc, 2);
                if (p_ov && !p_hs) begin
                    chk("hold_valid", out_valid, 1'b1);
                    chk("hold_data", out_data, p_data);
                end
                if (out_valid) begin
                    ov_seen = 1;
                    chk("out_data", out_data, exp[out_idx]);
                    chk("out_last", out_last, (out_idx == DEPTH - 1));
                    if (out_idx == bp_word) held++;
                end
                hs = out_valid && out_ready;
                p_ov = out_valid; p_hs = hs; p_data = out_data;
                if (out_valid && out_idx == stop_at && !out_ready) stopped = 1;
                if (hs) out_idx++;
            end
            cyc++;
        end

        if (expect_to) begin
            chk("timeout_seen", err_seen, 1'b1);
            chk("no_valid_on_timeout", ov_seen, 1'b0);
            chk("no_rd_on_timeout", rd_cnt, 0);
        end else if (stop_at >= DEPTH) begin
            chk("words_out", out_idx, DEPTH);
            chk("rd_count", rd_cnt, DEPTH);
            chk("start_count", start_cnt, 1);
            if (exp_rd_lat >= 0) chk("rd_after_done", first_rd - start_cyc, exp_rd_lat);
            @(posedge clk); #1;
            in_valid = 1'b0; out_ready = 1'b0;
            @(negedge clk);
            chk("busy_end", busy, 1'b0);
            chk("out_valid_end", out_valid, 1'b0);
            chk("in_ready_end", in_ready, 1'b1);
        end else begin
            chk("stopped_at_word", stopped, 1'b1);
        end
    endtask

    initial begin
        arr_t d, base;
        base = '{8'd45, 8'd12, 8'd78, 8'd34, 8'd56, 8'd89, 8'd23, 8'd67};

        // power-on reset
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1'b1);
        chk("busy_after_rst", busy, 1'b0);

        // full-rate job, then input gaps, then output backpressure on 34
        mode = 0;
        run_job(base, 0, -1, 0, 0, DEPTH, LAT + 2, 1'b0);
        foreach (d[i]) d[i] = N'($urandom);
        run_job(d, 1, -1, 0, 0, DEPTH, -1, 1'b0);
        run_job(base, 0, 2, 5, 0, DEPTH, -1, 1'b0);

        // stale done: readback only after the second rise
        mode = 2;
        foreach (d[i]) d[i] = N'($urandom);
        run_job(d, 0, -1, 0, 0, DEPTH, 15, 1'b0);

        // done never arrives
        mode = 1;
        foreach (d[i]) d[i] = N'($urandom);
        run_job(d, 0, -1, 0, 0, DEPTH, -1, 1'b1);

        // sticky error survives a following good job
        mode = 0;
        foreach (d[i]) d[i] = N'($urandom);
        run_job(d, 2, -1, 0, 1, DEPTH, -1, 1'b0);
        chk("err_sticky", err_timeout, 1'b1);

        // randomized jobs
        for (int k = 0; k < 6; k++) begin
            foreach (d[i]) d[i] = N'($urandom);
            run_job(d, 2, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 4)), 1,
                    DEPTH, -1, 1'b0);
        end

        // reset while word 4 is held, then a clean job
        foreach (d[i]) d[i] = N'($urandom);
        run_job(d, 0, -1, 0, 0, 4, -1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("in_ready_after_mid_rst", in_ready, 1'b1);
        run_job(base, 0, -1, 0, 0, DEPTH, LAT + 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
